pma_controller: RTL and testbench

- Sequencing and arbitration front-end for the PhaseMemoryAnchorRAM (64 x 144-bit anchors; window_id in bits [143:132]).
- Accepts anchor writes and window_id lookups from two requesters and arbitrates between them round-robin.
- Allocates write slots as a ring, tracks slot validity, and runs a pipelined linear scan that returns the lowest valid slot whose window_id matches.
- Sits between the phase engine / host requesters and the RAM instance, and owns all RAM ports.

---
 rtl/pma_pkg.sv | 28 ++
 rtl/pma_rr_arbiter.sv | 50 +++++
 rtl/pma_controller.sv | 207 ++++++++++++++++++++
 tb/tb_pma_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pma_pkg.sv
// Shared constants and types for the PhaseMemoryAnchorRAM front-end.
// The RAM holds DEPTH anchors of DATA_W bits. The window_id key sits in the
// top WID_W bits of each anchor.
package pma_pkg;

    localparam int PMA_DEPTH  = 64;
    localparam int PMA_ADDR_W = 6;
    localparam int PMA_DATA_W = 144;
    localparam int PMA_WID_W  = 12;

    // Bounds of the window_id field inside an anchor
    localparam int PMA_WID_HI = PMA_DATA_W - 1;
    localparam int PMA_WID_LO = PMA_DATA_W - PMA_WID_W;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } pma_state_e;

    // Which requester received the most recent grant
    typedef enum logic {
        GNT_LK = 1'b0,
        GNT_WR = 1'b1
    } pma_gnt_e;

endpackage

// File: rtl/pma_rr_arbiter.sv
// Two-requester round-robin arbiter (write vs lookup).
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   wr_req_i, lk_req_i     request (valid) from each requester
//   wr_allow_i, lk_allow_i requester may be granted in the current state
//   wr_gnt_o, lk_gnt_o     grant (drives the requester's ready)
// A requester that is allowed sees its grant high whether or not it is
// requesting. Only when both are allowed and both request does the one that
// won most recently lose for that cycle.
module pma_rr_arbiter
    import pma_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wr_req_i,
    input  logic wr_allow_i,
    input  logic lk_req_i,
    input  logic lk_allow_i,
    output logic wr_gnt_o,
    output logic lk_gnt_o
);

    pma_gnt_e last_q;
    pma_gnt_e last_d;
    logic     contend;

    always_comb begin
        contend  = wr_req_i && wr_allow_i && lk_req_i && lk_allow_i;
        wr_gnt_o = wr_allow_i && !(contend && (last_q == GNT_WR));
        lk_gnt_o = lk_allow_i && !(contend && (last_q == GNT_LK));

        // Remember whoever actually completed a handshake
        last_d = last_q;
        if (wr_req_i && wr_gnt_o) begin
            last_d = GNT_WR;
        end else if (lk_req_i && lk_gnt_o) begin
            last_d = GNT_LK;
        end
    end

    // Reset as if lookup won last, so the first contention goes to the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_LK;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/pma_controller.sv
// Sequencing/arbitration front-end for the PhaseMemoryAnchorRAM.
// Owns all RAM ports: allocates write slots as a ring, tracks slot validity
// and runs a two-stage pipelined scan (issue read, compare one cycle later)
// returning the lowest valid slot whose window_id matches the key.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   clr                  synchronous pulse, invalidates every slot
//   wr_valid/ready/data  anchor write request; wr_slot = slot of last write
//   lk_valid/ready       lookup request; lk_window_id = key
//   rsp_valid/ready      lookup result; rsp_hit, rsp_slot, rsp_data
//   occupancy            number of valid slots (0..DEPTH)
//   ram_*                external synchronous RAM (1-cycle read latency)
//   dbg_state            current FSM state
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. Ready depends only on state, clr, and (under contention) the other
// requester's valid. rsp_* stay stable while rsp_valid is high and
// rsp_ready is low.
module pma_controller
    import pma_pkg::*;
#(
    parameter int DEPTH  = PMA_DEPTH,
    parameter int ADDR_W = PMA_ADDR_W,
    parameter int DATA_W = PMA_DATA_W,
    parameter int WID_W  = PMA_WID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_slot,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [WID_W-1:0]  lk_window_id,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [ADDR_W-1:0] rsp_slot,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W:0]   occupancy,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_read_data,
    output pma_state_e        dbg_state
);

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   OCC_ONE   = (ADDR_W + 1)'(1);

    pma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W:0]   occ_q, occ_d;
    logic [ADDR_W-1:0] wr_slot_q, wr_slot_d;
    logic [WID_W-1:0]  key_q, key_d;
    logic [ADDR_W-1:0] issue_addr_q, issue_addr_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [ADDR_W-1:0] rsp_slot_q, rsp_slot_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic              wr_allow, lk_allow;
    logic              wr_gnt, lk_gnt;
    logic              wr_fire, lk_fire;
    logic [WID_W-1:0]  cmp_key;
    logic              cmp_match, cmp_last;

    // Gating with rst keeps every ready/strobe at 0 while reset is held
    assign wr_allow = !rst && !clr && ((state_q == IDLE) || (state_q == RESP));
    assign lk_allow = !rst && (state_q == IDLE);

    pma_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .wr_req_i   (wr_valid),
        .wr_allow_i (wr_allow),
        .lk_req_i   (lk_valid),
        .lk_allow_i (lk_allow),
        .wr_gnt_o   (wr_gnt),
        .lk_gnt_o   (lk_gnt)
    );

    assign wr_fire = wr_valid && wr_gnt;
    assign lk_fire = lk_valid && lk_gnt;

    // Compare stage works on the data for cmp_addr_q. The validity bit is
    // checked first so unwritten (X) slots never reach the key compare.
    assign cmp_key   = ram_read_data[DATA_W-1 -: WID_W];
    assign cmp_match = cmp_valid_q && valid_q[cmp_addr_q] && (cmp_key == key_q);
    assign cmp_last  = cmp_valid_q && (cmp_addr_q == ADDR_LAST);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        valid_d      = valid_q;
        occ_d        = occ_q;
        wr_slot_d    = wr_slot_q;
        key_d        = key_q;
        issue_addr_d = issue_addr_q;
        cmp_valid_d  = 1'b0;
        cmp_addr_d   = cmp_addr_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_slot_d   = rsp_slot_q;
        rsp_data_d   = rsp_data_q;

        // Slot bookkeeping; wr_fire is never high together with clr
        if (clr) begin
            valid_d  = '0;
            occ_d    = '0;
            wr_ptr_d = '0;
        end else if (wr_fire) begin
            valid_d[wr_ptr_q] = 1'b1;
            // Overwriting a live slot in the ring leaves occupancy unchanged
            if (!valid_q[wr_ptr_q]) begin
                occ_d = occ_q + OCC_ONE;
            end
            wr_slot_d = wr_ptr_q;
            wr_ptr_d  = wr_ptr_q + ADDR_ONE;
        end

        case (state_q)
            IDLE: begin
                if (lk_fire) begin
                    key_d        = lk_window_id;
                    issue_addr_d = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                issue_addr_d = issue_addr_q + ADDR_ONE;
                cmp_valid_d  = 1'b1;
                cmp_addr_d   = issue_addr_q;
                if (clr) begin
                    state_d = IDLE;
                end else if (cmp_match) begin
                    rsp_hit_d  = 1'b1;
                    rsp_slot_d = cmp_addr_q;
                    rsp_data_d = ram_read_data;
                    state_d    = RESP;
                end else if (cmp_last) begin
                    rsp_hit_d  = 1'b0;
                    rsp_slot_d = '0;
                    rsp_data_d = '0;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            valid_q      <= '0;
            occ_q        <= '0;
            wr_slot_q    <= '0;
            key_q        <= '0;
            issue_addr_q <= '0;
            cmp_valid_q  <= 1'b0;
            cmp_addr_q   <= '0;
            rsp_hit_q    <= 1'b0;
            rsp_slot_q   <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            valid_q      <= valid_d;
            occ_q        <= occ_d;
            wr_slot_q    <= wr_slot_d;
            key_q        <= key_d;
            issue_addr_q <= issue_addr_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_addr_q   <= cmp_addr_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_slot_q   <= rsp_slot_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign wr_ready       = wr_gnt;
    assign lk_ready       = lk_gnt;
    assign ram_write_en   = wr_fire;
    assign ram_write_addr = wr_fire ? wr_ptr_q : '0;
    assign ram_write_data = wr_fire ? wr_data : '0;
    assign ram_read_addr  = (state_q == SCAN) ? issue_addr_q : '0;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_hit        = rsp_hit_q;
    assign rsp_slot       = rsp_slot_q;
    assign rsp_data       = rsp_data_q;
    assign wr_slot        = wr_slot_q;
    assign occupancy      = occ_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pma_controller.sv
// Directed bench for pma_controller with a behavioural RAM, a reference
// model of slot validity/contents and an expected-response queue.
module tb_pma_controller;
    import pma_pkg::*;

    localparam int DEPTH = PMA_DEPTH;
    localparam int AW    = PMA_ADDR_W;
    localparam int DW    = PMA_DATA_W;
    localparam int WW    = PMA_WID_W;
    localparam int EW    = 1 + AW + DW;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst, clr;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] wr_slot;
    logic          lk_valid, lk_ready;
    logic [WW-1:0] lk_window_id;
    logic          rsp_valid, rsp_ready, rsp_hit;
    logic [AW-1:0] rsp_slot;
    logic [DW-1:0] rsp_data;
    logic [AW:0]   occupancy;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr, ram_read_addr;
    logic [DW-1:0] ram_write_data, ram_read_data;
    pma_state_e    dbg_state;

    always #5 clk = ~clk;

    pma_controller dut (
        .clk            (clk),
        .rst            (rst),
        .clr            (clr),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .wr_slot        (wr_slot),
        .lk_valid       (lk_valid),
        .lk_ready       (lk_ready),
        .lk_window_id   (lk_window_id),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_hit        (rsp_hit),
        .rsp_slot       (rsp_slot),
        .rsp_data       (rsp_data),
        .occupancy      (occupancy),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data),
        .dbg_state      (dbg_state)
    );

    // Behavioural RAM: unwritten words stay X, read data one cycle late
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= mem[ram_read_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int            tests = 0;
    int            fails = 0;
    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    logic          m_valid [DEPTH];
    logic [DW-1:0] m_data  [DEPTH];
    int            m_ptr;
    int            m_occ;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [WW-1:0] id);
        return {id, $urandom(), $urandom(), $urandom(), $urandom(), 4'h5};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
        m_occ = 0;
    endtask

    task automatic model_write(input logic [DW-1:0] d);
        if (!m_valid[m_ptr]) m_occ++;
        m_valid[m_ptr] = 1'b1;
        m_data[m_ptr]  = d;
        m_ptr = (m_ptr + 1) % DEPTH;
    endtask

    // Lowest valid slot with a matching key, and its response latency
    task automatic model_lookup(input logic [WW-1:0] key);
        logic [EW-1:0] e;
        int            lat;
        e   = '0;
        lat = DEPTH + 1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m_valid[i] && (m_data[i][DW-1 -: WW] == key)) begin
                e   = {1'b1, AW'(i), m_data[i]};
                lat = i + 2;
            end
        end
        exp_q.push_back(e);
        lat_q.push_back(lat);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [DW-1:0] d, input bit do_chk);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        #1;
        if (do_chk) begin
            chk("wr_ready", wr_ready, 1);
            chk("ram_write_en", ram_write_en, 1);
            chk("ram_write_addr", ram_write_addr, m_ptr);
            chk("ram_write_data", ram_write_data, d);
        end
        @(posedge clk);
        model_write(d);
        #1;
        wr_valid = 1'b0;
        if (do_chk) chk("wr_slot", wr_slot, (m_ptr + DEPTH - 1) % DEPTH);
    endtask

    task automatic do_lookup(input logic [WW-1:0] key, input bit push, output int t_acc);
        @(negedge clk);
        lk_valid     = 1'b1;
        lk_window_id = key;
        #1;
        chk("lk_ready", lk_ready, 1);
        @(posedge clk);
        if (push) model_lookup(key);
        #1;
        lk_valid = 1'b0;
        t_acc    = cyc;
    endtask

    task automatic wait_rsp(input int t_acc, input int hold, input string tag);
        logic [EW-1:0] e;
        int            lat;
        int            n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        e   = exp_q.pop_front();
        lat = lat_q.pop_front();
        if (!rsp_valid) begin
            chk({tag, "_timeout"}, rsp_valid, 1);
            return;
        end
        chk({tag, "_latency"}, cyc - t_acc, lat);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "_hit"}, rsp_hit, e[EW-1]);
            chk({tag, "_slot"}, rsp_slot, e[EW-2 -: AW]);
            chk({tag, "_data"}, rsp_data, e[DW-1:0]);
            if (h < hold) begin
                @(posedge clk);
                #1;
                chk({tag, "_held_valid"}, rsp_valid, 1);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, rsp_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int            t;
        int            seen;
        logic [DW-1:0] d;

        rst          = 1'b1;
        clr          = 1'b0;
        wr_valid     = 1'b1;
        wr_data      = '1;
        lk_valid     = 1'b1;
        lk_window_id = '0;
        rsp_ready    = 1'b0;
        model_clear();

        // Reset: every output 0 even with requests pending
        #12;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_lk_ready", lk_ready, 0);
        chk("rst_ram_we", ram_write_en, 0);
        chk("rst_ram_waddr", ram_write_addr, 0);
        chk("rst_ram_wdata", ram_write_data, 0);
        chk("rst_ram_raddr", ram_read_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_slot", rsp_slot, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_wr_slot", wr_slot, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_state", dbg_state, IDLE);
        wr_valid = 1'b0;
        lk_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Three anchors into slots 0..2
        do_write(mk(12'h010), 1);
        do_write(mk(12'h042), 1);
        do_write(mk(12'h077), 1);
        chk("occ_after_3", occupancy, 3);

        // Hit on slot 1, then a miss across unwritten X slots
        do_lookup(12'h042, 1, t);
        wait_rsp(t, 0, "lk042");
        do_lookup(12'h0FF, 1, t);
        wait_rsp(t, 0, "lk0ff_miss");

        // Contention: last grant was the lookup, so the write goes first
        d = mk(12'h0AA);
        @(negedge clk);
        wr_valid     = 1'b1;
        wr_data      = d;
        lk_valid     = 1'b1;
        lk_window_id = 12'h0AA;
        #1;
        chk("cont1_wr_ready", wr_ready, 1);
        chk("cont1_lk_ready", lk_ready, 0);
        @(posedge clk);
        model_write(d);
        @(negedge clk);
        chk("cont2_wr_ready", wr_ready, 0);
        chk("cont2_lk_ready", lk_ready, 1);
        @(posedge clk);
        model_lookup(12'h0AA);
        #1;
        t = cyc;
        for (int c = 3; c <= 4; c++) begin
            @(negedge clk);
            chk("cont_scan_wr_ready", wr_ready, 0);
            chk("cont_scan_lk_ready", lk_ready, 0);
        end
        wr_valid = 1'b0;
        lk_valid = 1'b0;
        wait_rsp(t, 5, "cont_hold");

        // clr empties the bitmap and rewinds the ring pointer
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        clr = 1'b0;
        chk("clr_occupancy", occupancy, 0);

        // 65 distinct ids: ring wraps, slot 0 now holds id #64
        for (int i = 0; i <= DEPTH; i++) begin
            do_write(mk(WW'(12'h100 + i)), (i == DEPTH));
        end
        chk("wrap_occupancy", occupancy, DEPTH);
        do_lookup(12'h100, 1, t);
        wait_rsp(t, 0, "wrap_id0_miss");
        do_lookup(12'h140, 1, t);
        wait_rsp(t, 0, "wrap_id64_slot0");
        do_lookup(12'h13F, 1, t);
        wait_rsp(t, 0, "wrap_id63_slot63");

        // clr mid-scan aborts with no response
        do_lookup(12'h13F, 0, t);
        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        clr  = 1'b0;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen++;
        end
        chk("clr_abort_no_rsp", seen, 0);
        chk("clr_abort_state", dbg_state, IDLE);
        chk("clr_abort_occ", occupancy, 0);
        do_lookup(12'h13F, 1, t);
        wait_rsp(t, 0, "after_clr_miss");

        // rst mid-scan: outputs drop before the next clock edge
        do_write(mk(12'h055), 1);
        do_lookup(12'h999, 0, t);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_state", dbg_state, IDLE);
        chk("arst_ram_raddr", ram_read_addr, 0);
        chk("arst_lk_ready", lk_ready, 0);
        chk("arst_wr_ready", wr_ready, 0);
        chk("arst_occupancy", occupancy, 0);
        chk("arst_wr_slot", wr_slot, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        do_lookup(12'h055, 1, t);
        wait_rsp(t, 0, "after_rst_miss");
        chk("after_rst_occ", occupancy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
